// File: rtl/clb_multi_ble_pkg.sv
// Shared definitions for the multi-BLE configurable logic block:
// config FSM encoding, default geometry and config-layout size helpers.
package clb_multi_ble_pkg;

    typedef enum logic [1:0] {
        ST_UNCONFIG = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_ACTIVE   = 2'd2
    } cfg_state_e;

    localparam int DEF_CLB_IN_WIDTH = 8;
    localparam int DEF_CLB_BLE_NUM  = 4;
    localparam int DEF_LUT_K        = 4;

    // Mux select width: one extra code beyond the last source means "constant 0".
    function automatic int sel_width(input int src_num);
        return $clog2(src_num + 1);
    endfunction

    // Per-BLE config slice: truth table, LUT_K selects, ff_init, is_comb.
    function automatic int ble_bits(input int lut_k, input int sel_w);
        return (2 ** lut_k) + lut_k * sel_w + 2;
    endfunction

endpackage

// File: rtl/clb_multi_ble_if.sv
// Tile-facing bus of the CLB: connection-box inputs, switch-box outputs
// and the fabric configuration scan chain.
interface clb_multi_ble_if
    import clb_multi_ble_pkg::*;
#(
    parameter int CLB_IN_WIDTH = DEF_CLB_IN_WIDTH,
    parameter int CLB_BLE_NUM  = DEF_CLB_BLE_NUM
);
    logic [CLB_IN_WIDTH-1:0] clb_in;
    logic [CLB_BLE_NUM-1:0]  out;
    logic                    scan_in;
    logic                    scan_en;
    logic                    scan_out;
    logic                    cfg_done;
    logic                    cfg_err;

    modport master (
        output clb_in, scan_in, scan_en,
        input  out, scan_out, cfg_done, cfg_err
    );

    modport slave (
        input  clb_in, scan_in, scan_en,
        output out, scan_out, cfg_done, cfg_err
    );
endinterface

// File: rtl/clb_multi_ble_ble_k.sv
// One basic logic element: LUT_K-input crossbar over CLB inputs and gated
// BLE outputs, LUT_K-input LUT, output FF with init load, comb/reg select.
module clb_ble_k
    import clb_multi_ble_pkg::*;
#(
    parameter int CLB_IN_WIDTH = DEF_CLB_IN_WIDTH,
    parameter int CLB_BLE_NUM  = DEF_CLB_BLE_NUM,
    parameter int LUT_K        = DEF_LUT_K,
    parameter int SEL_W        = sel_width(CLB_IN_WIDTH + CLB_BLE_NUM),
    parameter int BLE_BITS     = ble_bits(LUT_K, SEL_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLE_BITS-1:0]     cfg_slice,
    input  logic [CLB_IN_WIDTH-1:0] clb_in,
    input  logic [CLB_BLE_NUM-1:0]  fb,         // already gated by the block's active state
    input  logic                    active,
    input  logic                    load_init,
    output logic                    ble_out
);
    localparam int SRC_NUM  = CLB_IN_WIDTH + CLB_BLE_NUM;
    localparam int LUT_N    = 2 ** LUT_K;
    localparam int SEL_OFS  = LUT_N;
    localparam int INIT_OFS = SEL_OFS + LUT_K * SEL_W;
    localparam int COMB_OFS = INIT_OFS + 1;

    logic [SRC_NUM-1:0]          src;
    logic [LUT_K-1:0][SEL_W-1:0] sel;
    logic [LUT_K-1:0]            lut_addr;
    logic [LUT_N-1:0]            lut;
    logic                        lut_out;
    logic                        ff_init;
    logic                        is_comb;
    logic                        ff_d, ff_q;

    // Sources are numbered CLB inputs first, then BLE outputs.
    assign src     = {fb, clb_in};
    assign lut     = cfg_slice[LUT_N-1:0];
    assign ff_init = cfg_slice[INIT_OFS];
    assign is_comb = cfg_slice[COMB_OFS];

    // Crossbar: select codes past the last source tie the LUT input low.
    for (genvar j = 0; j < LUT_K; j++) begin : g_xbar
        assign sel[j]      = cfg_slice[SEL_OFS + j*SEL_W +: SEL_W];
        assign lut_addr[j] = (int'(sel[j]) < SRC_NUM) ? src[sel[j]] : 1'b0;
    end

    assign lut_out = lut[lut_addr];

    // FF takes ff_init on entry to ACTIVE, follows the LUT while active, else holds.
    always_comb begin
        ff_d = ff_q;
        if (load_init) begin
            ff_d = ff_init;
        end else if (active) begin
            ff_d = lut_out;
        end
    end

    // Output flop with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign ble_out = active ? (is_comb ? lut_out : ff_q) : 1'b0;

endmodule

// File: rtl/clb_multi_ble.sv
// Configurable logic block: scan-loaded config shift register, bit counter
// and load-validation FSM, plus CLB_BLE_NUM BLEs with full local feedback.
module clb_multi_ble
    import clb_multi_ble_pkg::*;
#(
    parameter int CLB_IN_WIDTH = DEF_CLB_IN_WIDTH,
    parameter int CLB_BLE_NUM  = DEF_CLB_BLE_NUM,
    parameter int LUT_K        = DEF_LUT_K
) (
    input  logic              clk,
    input  logic              rst,
    clb_multi_ble_if.slave    bus
);
    localparam int SRC_NUM  = CLB_IN_WIDTH + CLB_BLE_NUM;
    localparam int SEL_W    = sel_width(SRC_NUM);
    localparam int BLE_BITS = ble_bits(LUT_K, SEL_W);
    localparam int CFG_BITS = CLB_BLE_NUM * BLE_BITS;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0]    cfg_d, cfg_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    cfg_state_e             state_d, state_q;
    logic                   err_d, err_q;
    logic                   done_d, done_q;
    logic                   load_init;
    logic [CLB_BLE_NUM-1:0] out_w;

    // Shift on every scan_en cycle; on scan_en falling, accept the load only
    // if exactly CFG_BITS bits went in, otherwise flag and fall back.
    always_comb begin
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        err_d     = 1'b0;
        load_init = 1'b0;
        if (bus.scan_en) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], bus.scan_in};
            if (state_q != ST_SHIFT) begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_ONE;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (state_q == ST_SHIFT) begin
            if (cnt_q == CNT_FULL) begin
                state_d   = ST_ACTIVE;
                load_init = 1'b1;
            end else begin
                state_d = ST_UNCONFIG;
                err_d   = 1'b1;
            end
        end
        done_d = (state_d == ST_ACTIVE);
    end

    // Config/FSM registers; reset wins over an in-flight shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_UNCONFIG;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // done_q mirrors state_q == ST_ACTIVE and doubles as the BLE enable.
    for (genvar b = 0; b < CLB_BLE_NUM; b++) begin : g_ble
        clb_ble_k #(
            .CLB_IN_WIDTH (CLB_IN_WIDTH),
            .CLB_BLE_NUM  (CLB_BLE_NUM),
            .LUT_K        (LUT_K),
            .SEL_W        (SEL_W),
            .BLE_BITS     (BLE_BITS)
        ) u_ble (
            .clk       (clk),
            .rst       (rst),
            .cfg_slice (cfg_q[b*BLE_BITS +: BLE_BITS]),
            .clb_in    (bus.clb_in),
            .fb        (out_w),
            .active    (done_q),
            .load_init (load_init),
            .ble_out   (out_w[b])
        );
    end

    assign bus.out      = out_w;
    assign bus.scan_out = cfg_q[CFG_BITS-1];
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;

endmodule
